wb_write_scheduler: RTL and testbench

- Writeback-port scheduler between the dual-result WB stage and a single-write-port register file.
- Accepts up to two register write requests per cycle (slot A = ALU1/load result, slot B = ALU2 result), buffers them in program order, and drains one write per cycle to the register file.
- Raises stall to freeze the pipeline when buffer space runs low.
- Provides a forwarding lookup so readers see values still waiting in the buffer.

---
 rtl/wb_write_scheduler.sv | 123 ++++++++++++
 tb/tb_wb_write_scheduler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_scheduler.sv
// Writeback-port scheduler: buffers up to two register writes per cycle in
// program order and drains one write per cycle into a single-port register
// file. Pending writes stay visible through a combinational forwarding lookup.
module wb_write_scheduler #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                       clock2,
  input  logic                       reset,
  input  logic [1:0]                 WRITEBACK_WRITEBACK,
  input  logic [ADDR_W-1:0]          destination_A,
  input  logic [ADDR_W-1:0]          destination_B,
  input  logic [DATA_W-1:0]          data_A,
  input  logic [DATA_W-1:0]          data_B,
  output logic                       stall,
  output logic                       rf_we,
  output logic [ADDR_W-1:0]          rf_waddr,
  output logic [DATA_W-1:0]          rf_wdata,
  output logic [$clog2(DEPTH):0]     pending_count,
  input  logic [ADDR_W-1:0]          lookup_addr,
  output logic                       lookup_hit,
  output logic [DATA_W-1:0]          lookup_data,
  output logic                       err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              req_any;
  logic              accept;
  logic              push_a;
  logic              push_b;
  logic              pop;
  logic [CNT_W-1:0]  push_cnt;

  // Stall keeps at least two free entries so a dual push always fits.
  assign stall         = (count > CNT_W'(DEPTH - 2));
  assign pending_count = count;

  // Request qualification: r0 is dropped, and a dual write to the same
  // register keeps only the younger slot B.
  always_comb begin
    req_any  = (WRITEBACK_WRITEBACK != 2'd0);
    accept   = req_any && !stall;
    push_a   = accept && WRITEBACK_WRITEBACK[0] && (destination_A != '0) &&
               !(WRITEBACK_WRITEBACK == 2'd3 && destination_A == destination_B);
    push_b   = accept && WRITEBACK_WRITEBACK[1] && (destination_B != '0);
    pop      = (count != '0);
    push_cnt = CNT_W'(push_a) + CNT_W'(push_b);
  end

  // Buffer storage: A goes first, B lands behind it (or at the tail alone).
  always_ff @(posedge clock2) begin
    if (push_a) begin
      mem_addr[wr_ptr] <= destination_A;
      mem_data[wr_ptr] <= data_A;
    end
    if (push_b) begin
      if (push_a) begin
        mem_addr[wr_ptr + PTR_W'(1)] <= destination_B;
        mem_data[wr_ptr + PTR_W'(1)] <= data_B;
      end else begin
        mem_addr[wr_ptr] <= destination_B;
        mem_data[wr_ptr] <= data_B;
      end
    end
  end

  // Pointers, occupancy, drain register and sticky error flag.
  always_ff @(posedge clock2) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      err      <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push_cnt);
      count  <= count + push_cnt - CNT_W'(pop);
      rf_we  <= pop;
      if (pop) begin
        rf_waddr <= mem_addr[rd_ptr];
        rf_wdata <= mem_data[rd_ptr];
        rd_ptr   <= rd_ptr + PTR_W'(1);
      end
      if (stall && req_any) begin
        err <= 1'b1;
      end
    end
  end

  // Forwarding search from oldest (output register) to youngest (tail);
  // later matches overwrite earlier ones so the youngest wins.
  always_comb begin
    logic [PTR_W-1:0] slot;
    lookup_hit  = 1'b0;
    lookup_data = '0;
    slot        = '0;
    if (lookup_addr != '0) begin
      if (rf_we && rf_waddr == lookup_addr) begin
        lookup_hit  = 1'b1;
        lookup_data = rf_wdata;
      end
      for (int k = 0; k < DEPTH; k++) begin
        slot = rd_ptr + PTR_W'(k);
        if ((CNT_W'(k) < count) && (mem_addr[slot] == lookup_addr)) begin
          lookup_hit  = 1'b1;
          lookup_data = mem_data[slot];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_write_scheduler.sv
// Directed self-checking bench for wb_write_scheduler (DEPTH=4).
module tb_wb_write_scheduler;

  logic        clock2;
  logic        reset;
  logic [1:0]  WRITEBACK_WRITEBACK;
  logic [4:0]  destination_A;
  logic [4:0]  destination_B;
  logic [31:0] data_A;
  logic [31:0] data_B;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [2:0]  pending_count;
  logic [4:0]  lookup_addr;
  logic        lookup_hit;
  logic [31:0] lookup_data;
  logic        err;

  int tests_run = 0;
  int tests_failed = 0;

  wb_write_scheduler #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) dut (
    .clock2(clock2),
    .reset(reset),
    .WRITEBACK_WRITEBACK(WRITEBACK_WRITEBACK),
    .destination_A(destination_A),
    .destination_B(destination_B),
    .data_A(data_A),
    .data_B(data_B),
    .stall(stall),
    .rf_we(rf_we),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .pending_count(pending_count),
    .lookup_addr(lookup_addr),
    .lookup_hit(lookup_hit),
    .lookup_data(lookup_data),
    .err(err)
  );

  initial clock2 = 1'b0;
  always #5 clock2 = ~clock2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock2);
    #1;
  endtask

  task automatic req(input logic [1:0] code, input logic [4:0] da, input logic [31:0] va,
                     input logic [4:0] db, input logic [31:0] vb);
    WRITEBACK_WRITEBACK = code;
    destination_A = da;
    data_A = va;
    destination_B = db;
    data_B = vb;
  endtask

  task automatic expect_wr(input string tag, input logic [4:0] a, input logic [31:0] d);
    check({tag, "_we"}, 32'(rf_we), 32'd1);
    check({tag, "_addr"}, 32'(rf_waddr), 32'(a));
    check({tag, "_data"}, rf_wdata, d);
  endtask

  initial begin
    reset = 1'b1;
    lookup_addr = 5'd1;
    req(2'd0, 5'd0, 32'd0, 5'd0, 32'd0);
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_we", 32'(rf_we), 32'd0);
    check("rst_waddr", 32'(rf_waddr), 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    check("rst_pending", 32'(pending_count), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_hit", 32'(lookup_hit), 32'd0);

    // Single writes on consecutive cycles
    req(2'd1, 5'd1, 32'h15, 5'd0, 32'd0);
    tick();
    check("s1_pending", 32'(pending_count), 32'd1);
    check("s1_we0", 32'(rf_we), 32'd0);
    req(2'd1, 5'd2, 32'h15, 5'd0, 32'd0);
    tick();
    expect_wr("s1_w1", 5'd1, 32'h15);
    check("s1_pending2", 32'(pending_count), 32'd1);
    req(2'd0, 5'd0, 32'd0, 5'd0, 32'd0);
    tick();
    expect_wr("s1_w2", 5'd2, 32'h15);
    check("s1_pending3", 32'(pending_count), 32'd0);
    tick();
    check("s1_idle_we", 32'(rf_we), 32'd0);
    check("s1_hold_addr", 32'(rf_waddr), 32'd2);

    // Dual write plus forwarding of slot B
    lookup_addr = 5'd6;
    req(2'd3, 5'd5, 32'h8, 5'd6, 32'h0012_0000);
    #1;
    check("d_incoming_nohit", 32'(lookup_hit), 32'd0);
    tick();
    check("d_pending", 32'(pending_count), 32'd2);
    check("d_hit0", 32'(lookup_hit), 32'd1);
    check("d_data0", lookup_data, 32'h0012_0000);
    req(2'd0, 5'd0, 32'd0, 5'd0, 32'd0);
    tick();
    expect_wr("d_w5", 5'd5, 32'h8);
    check("d_hit1", 32'(lookup_hit), 32'd1);
    tick();
    expect_wr("d_w6", 5'd6, 32'h0012_0000);
    check("d_hit_outreg", 32'(lookup_hit), 32'd1);
    check("d_data_outreg", lookup_data, 32'h0012_0000);
    tick();
    check("d_we_off", 32'(rf_we), 32'd0);
    check("d_hit_off", 32'(lookup_hit), 32'd0);
    check("d_data_miss", lookup_data, 32'd0);

    // r0 filter
    req(2'd3, 5'd0, 32'h2, 5'd7, 32'h1);
    tick();
    check("r0_pending", 32'(pending_count), 32'd1);
    req(2'd0, 5'd0, 32'd0, 5'd0, 32'd0);
    tick();
    expect_wr("r0_w7", 5'd7, 32'h1);
    tick();
    check("r0_we_off", 32'(rf_we), 32'd0);

    // Coalesce same destination
    req(2'd3, 5'd9, 32'hA, 5'd9, 32'hB);
    tick();
    check("co_pending", 32'(pending_count), 32'd1);
    req(2'd0, 5'd0, 32'd0, 5'd0, 32'd0);
    tick();
    expect_wr("co_w9", 5'd9, 32'hB);
    tick();
    check("co_we_off", 32'(rf_we), 32'd0);

    // Youngest match wins over output register
    lookup_addr = 5'd3;
    req(2'd1, 5'd3, 32'h1, 5'd0, 32'd0);
    tick();
    req(2'd1, 5'd3, 32'h2, 5'd0, 32'd0);
    tick();
    check("yg_hit", 32'(lookup_hit), 32'd1);
    check("yg_data", lookup_data, 32'h2);
    req(2'd0, 5'd0, 32'd0, 5'd0, 32'd0);
    tick();
    tick();
    check("yg_drained", 32'(pending_count), 32'd0);

    // Back-pressure and err
    req(2'd3, 5'd10, 32'd10, 5'd11, 32'd11);
    tick();
    check("bp_cnt2", 32'(pending_count), 32'd2);
    check("bp_stall0", 32'(stall), 32'd0);
    req(2'd3, 5'd12, 32'd12, 5'd13, 32'd13);
    tick();
    check("bp_cnt3", 32'(pending_count), 32'd3);
    check("bp_stall1", 32'(stall), 32'd1);
    expect_wr("bp_w10", 5'd10, 32'd10);
    req(2'd3, 5'd14, 32'd14, 5'd15, 32'd15);
    tick();
    check("bp_err", 32'(err), 32'd1);
    check("bp_cnt_after", 32'(pending_count), 32'd2);
    expect_wr("bp_w11", 5'd11, 32'd11);
    req(2'd0, 5'd0, 32'd0, 5'd0, 32'd0);
    tick();
    expect_wr("bp_w12", 5'd12, 32'd12);
    tick();
    expect_wr("bp_w13", 5'd13, 32'd13);
    tick();
    check("bp_no14", 32'(rf_we), 32'd0);
    check("bp_empty", 32'(pending_count), 32'd0);
    check("bp_err_sticky", 32'(err), 32'd1);

    // Wrap-around: r1..r20 with data = index
    for (int i = 1; i <= 20; i++) begin
      req(2'd1, 5'(i), 32'(i), 5'd0, 32'd0);
      tick();
      if (i > 1) expect_wr($sformatf("wr_%0d", i - 1), 5'(i - 1), 32'(i - 1));
    end
    req(2'd0, 5'd0, 32'd0, 5'd0, 32'd0);
    tick();
    expect_wr("wr_20", 5'd20, 32'd20);
    check("wr_pending0", 32'(pending_count), 32'd0);
    tick();
    check("wr_we_off", 32'(rf_we), 32'd0);

    // Reset mid-drain
    req(2'd3, 5'd21, 32'd21, 5'd22, 32'd22);
    tick();
    req(2'd3, 5'd23, 32'd23, 5'd24, 32'd24);
    tick();
    check("rm_cnt3", 32'(pending_count), 32'd3);
    req(2'd0, 5'd0, 32'd0, 5'd0, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rm_we", 32'(rf_we), 32'd0);
    check("rm_pending", 32'(pending_count), 32'd0);
    check("rm_stall", 32'(stall), 32'd0);
    check("rm_err", 32'(err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rm_quiet_%0d", i), 32'(rf_we), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
